imem_writer: RTL and testbench

Writable 32-entry, 8-bit instruction store with a byte-stream load port, used in place of the fixed instruction ROM when programs are downloaded at run time. A host or serial front end streams instruction bytes in with a valid/ready handshake. The block writes them sequentially from address 0 and holds the CPU while loading. The CPU fetches via the same combinational `instruction`/`Read_Address` port as the ROM, using the same 2-bit-field encoding.

---
 rtl/imem_writer.sv | 158 +++++++++++++++
 tb/tb_imem_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_writer.sv
// imem_writer: DEPTH x 8 writable instruction store, loaded from a valid/ready byte stream.
// Build macro IMEM_WRITER_CHECKSUM_EN turns the in_last byte into a checksum byte instead of data.
module imem_writer #(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_start,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    input  logic       in_last,
    output logic       in_ready,
    output logic       busy,
    output logic       cpu_hold,
    output logic       load_done,
    output logic [6:0] load_count,
    output logic       checksum_err,
    input  logic [7:0] Read_Address,
    output logic [7:0] instruction,
    output logic [1:0] dbg_state_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [PW-1:0] wr_ptr_q;
    logic [6:0]    count_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [7:0]    mem_q [DEPTH];

    logic beat;
    logic last_entry;
    logic load_end;
    logic mem_we;

    // Handshake: in_ready is high for the whole LOAD state; a byte transfers on every
    // rising edge where in_valid && in_ready. The source may not retract a byte early.
    assign beat       = in_valid && ready_q;
    assign last_entry = (wr_ptr_q == LAST_PTR);
    assign load_end   = in_last || last_entry;

`ifdef IMEM_WRITER_CHECKSUM_EN
    assign mem_we = beat && !in_last;
`else
    assign mem_we = beat;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (load_start) begin
                        state_q  <= S_LOAD;
                        wr_ptr_q <= '0;
                        count_q  <= '0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        if (mem_we) begin
                            wr_ptr_q <= wr_ptr_q + PW'(1);
                            count_q  <= count_q + 7'd1;
                        end
                        if (load_end) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_WRITER_CHECKSUM_EN
    logic [7:0] sum_q;

    // Sum plus checksum byte must wrap to zero; filling the store without a checksum is an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= 8'h00;
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && load_start) begin
            sum_q <= 8'h00;
            err_q <= 1'b0;
        end else if (state_q == S_LOAD && beat) begin
            if (in_last) begin
                err_q <= ((sum_q + in_byte) != 8'h00);
            end else begin
                sum_q <= sum_q + in_byte;
                if (last_entry) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
`else
    assign err_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_byte;
        end
    end

    always_comb begin
        instruction = 8'h00;
        if (!busy_q && ({1'b0, Read_Address} < DEPTH_9)) begin
            instruction = mem_q[Read_Address[AW-1:0]];
        end
    end

    assign in_ready     = ready_q;
    assign busy         = busy_q;
    assign cpu_hold     = busy_q;
    assign load_done    = done_q;
    assign load_count   = count_q;
    assign checksum_err = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_writer.sv
// tb_imem_writer: directed and randomized load streams checked every cycle against a
// behavioural model of the instruction store, plus literal pins on key scenarios.
module tb_imem_writer;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_last = 1'b0;
    logic [7:0] Read_Address = 8'h00;
    logic       in_ready;
    logic       busy;
    logic       cpu_hold;
    logic       load_done;
    logic [6:0] load_count;
    logic       checksum_err;
    logic [7:0] instruction;
    logic [1:0] dbg_state_o;

    imem_writer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
        .in_byte(in_byte), .in_last(in_last), .in_ready(in_ready), .busy(busy),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_count(load_count),
        .checksum_err(checksum_err), .Read_Address(Read_Address),
        .instruction(instruction), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit ra_fixed = 1'b0;

    // Behavioural model: a loading flag, a one-cycle done flag, and plain integer counters.
    bit       m_loading = 1'b0;
    bit       m_done = 1'b0;
    int       m_ptr = 0;
    int       m_cnt = 0;
    bit       m_err = 1'b0;
    int       m_sum = 0;
    bit [7:0] m_mem [DEPTH];

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_loading = 1'b0; m_done = 1'b0; m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_sum = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_loading) begin
            if (in_valid) begin
`ifdef IMEM_WRITER_CHECKSUM_EN
                if (in_last) begin
                    m_err = ((m_sum + int'(in_byte)) % 256) != 0;
                    m_loading = 1'b0; m_done = 1'b1;
                end else begin
                    m_mem[m_ptr] = in_byte;
                    m_sum = m_sum + int'(in_byte);
                    m_ptr++; m_cnt++;
                    if (m_ptr == DEPTH) begin
                        m_err = 1'b1; m_loading = 1'b0; m_done = 1'b1;
                    end
                end
`else
                m_mem[m_ptr] = in_byte;
                m_ptr++; m_cnt++;
                if (in_last || m_ptr == DEPTH) begin
                    m_loading = 1'b0; m_done = 1'b1;
                end
`endif
            end
        end else if (load_start) begin
            m_loading = 1'b1; m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_sum = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] exp_instr;
            if (m_loading || Read_Address >= DEPTH) exp_instr = 8'h00;
            else exp_instr = m_mem[Read_Address];
            cmp("in_ready", in_ready, m_loading);
            cmp("busy", busy, m_loading);
            cmp("cpu_hold", cpu_hold, m_loading);
            cmp("load_done", load_done, m_done);
            cmp("load_count", load_count, m_cnt);
            cmp("checksum_err", checksum_err, m_err);
            cmp("instruction", instruction, exp_instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!ra_fixed) Read_Address = 8'($urandom_range(0, 63));
    endtask

    task automatic quiet();
        load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_byte = 8'($urandom_range(0, 255));
    endtask

    task automatic read_pin(input string name, input int addr, input logic [7:0] exp);
        ra_fixed = 1'b1;
        Read_Address = 8'(addr);
        @(negedge clk);
        cmp(name, instruction, exp);
        tick();
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes13 [13];
        logic [7:0] last32;
        reset = 1'b1;
        quiet();
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        for (int a = 0; a < DEPTH; a++) read_pin("reset_read", a, 8'h00);
        ra_fixed = 1'b0;

        // 13-byte load with in_last on the final byte
        bytes13[0] = 8'h41; bytes13[1] = 8'h00; bytes13[12] = 8'h79;
        for (int i = 2; i < 12; i++) bytes13[i] = 8'($urandom_range(0, 255));
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; in_byte = bytes13[i]; in_last = (i == 12);
            tick();
        end
        quiet();
        @(negedge clk);
        cmp("done_pulse_13", load_done, 1'b1);
        cmp("count_13", load_count, 7'd13);
        tick();
        @(negedge clk);
        cmp("done_gone_13", load_done, 1'b0);
        tick();
`ifdef IMEM_WRITER_CHECKSUM_EN
        read_pin("mem12_kept", 12, 8'h00);
`else
        read_pin("mem12", 12, 8'h79);
        read_pin("mem0", 0, 8'h41);
`endif
        read_pin("mem13", 13, 8'h00);
        read_pin("addr_oob", 40, 8'h00);
        ra_fixed = 1'b0;

        // 40 bytes offered on alternate cycles with no in_last: exactly DEPTH writes
        last32 = 8'h00;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            in_valid = (i % 2 == 0);
            in_byte = 8'($urandom_range(0, 255));
            in_last = 1'b0;
            if (i == 62) last32 = in_byte;
            tick();
        end
        quiet();
        @(negedge clk);
        cmp("count_32", load_count, 7'd32);
        cmp("ready_after_full", in_ready, 1'b0);
        tick();
        read_pin("mem31", 31, last32);
        ra_fixed = 1'b0;

        // reset after beat 5 of a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_byte = 8'($urandom_range(1, 255)); in_last = 1'b0;
            tick();
        end
        quiet();
        ra_fixed = 1'b1;
        Read_Address = 8'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        cmp("busy_after_reset", busy, 1'b0);
        cmp("mem0_after_reset", instruction, 8'h00);
        tick();
        read_pin("mem4_after_reset", 4, 8'h00);
        ra_fixed = 1'b0;

        // load_start held through LOAD and DONE
        load_start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_byte = 8'($urandom_range(0, 255)); in_last = (i == 2);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        cmp("held_done", load_done, 1'b1);
        cmp("held_done_busy", busy, 1'b0);
        tick();
        @(negedge clk);
        cmp("held_idle_busy", busy, 1'b0);
        tick();
        @(negedge clk);
        cmp("held_restart", busy, 1'b1);
        load_start = 1'b0;
        tick();
        in_valid = 1'b1; in_last = 1'b1; in_byte = 8'h00;
        tick();
        quiet();
        tick();
        tick();

`ifdef IMEM_WRITER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
            in_valid = 1'b1; in_last = 1'b0; in_byte = 8'h10;
            tick();
            in_byte = 8'h20;
            tick();
            in_last = 1'b1; in_byte = (k == 0) ? 8'hD0 : 8'hD1;
            tick();
            quiet();
            @(negedge clk);
            cmp("csum_count", load_count, 7'd2);
            cmp("csum_err", checksum_err, (k == 0) ? 1'b0 : 1'b1);
            tick();
            tick();
        end
`endif

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            load_start = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_byte = 8'($urandom_range(0, 255));
            in_last = ($urandom_range(0, 15) == 0);
            tick();
        end
        reset = 1'b0;
        quiet();
        for (int c = 0; c < 4; c++) tick();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
